// File: rtl/param_updown_counter.sv
// Loadable up/down counter with programmable modulus, wrap or saturate at the
// terminal value, cascadable carry/borrow-out and a sticky terminal-event flag.
module param_updown_counter #(
    parameter int unsigned      WIDTH    = 4,
    parameter logic [WIDTH-1:0] MAXV     = '1,
    parameter bit               SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             cen,
    input  logic             ci,
    input  logic             up,
    input  logic             clr_ovf,
    input  logic [WIDTH-1:0] parIn,
    output logic [WIDTH-1:0] parOut,
    output logic             co,
    output logic             ovf
);

    logic             terminal;
    logic             step;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] next_cnt;

    always_comb begin
        terminal = up ? (parOut == MAXV) : (parOut == '0);
        step     = cen & ci & ~ld;
        co       = step & terminal;
        load_val = (parIn > MAXV) ? MAXV : parIn;

        next_cnt = parOut;
        if (ld) begin
            next_cnt = load_val;
        end else if (step) begin
            // At the terminal value: wrap to the opposite end, or hold when saturating.
            if (terminal) begin
                if (!SATURATE) begin
                    next_cnt = up ? '0 : MAXV;
                end
            end else begin
                next_cnt = up ? parOut + 1'b1 : parOut - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parOut <= '0;
            ovf    <= 1'b0;
        end else begin
            parOut <= next_cnt;
            if (co) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: doc/param_updown_counter.md
PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits; legal range 2..32.
REQ-002 Parameter MAXV, default 2**WIDTH-1: highest count value (modulus MAXV+1); legal range 1..2**WIDTH-1.
REQ-003 Parameter SATURATE, default 0: 0 = wrap at terminal, 1 = hold at terminal.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 ld  input  1  synchronous parallel load strobe.
REQ-007 cen  input  1  count enable.
REQ-008 ci  input  1  carry-in from the previous stage; counting needs cen=1 and ci=1.
REQ-009 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-010 clr_ovf  input  1  synchronous clear of the sticky overflow flag.
REQ-011 parIn  input  WIDTH  parallel load value.
REQ-012 parOut  output  WIDTH  current count, registered.
REQ-013 co  output  1  carry/borrow-out to the next stage, combinational.
REQ-014 ovf  output  1  sticky terminal-event flag, registered.

Function
REQ-015 Priority per edge: ld, then count step, then hold.
REQ-016 ld=1: parOut SHALL load min(parIn, MAXV) on the next edge, whatever cen, ci or up are.
REQ-017 Step condition: ld=0, cen=1, ci=1.
  - up=1: parOut+1
  - up=0: parOut-1
REQ-018 Terminal state:
  - up=1: parOut==MAXV
  - up=0: parOut==0
REQ-019 Step at terminal, SATURATE=0:
  - up=1: MAXV -> 0
  - up=0: 0 -> MAXV
REQ-020 Step at terminal, SATURATE=1: parOut SHALL hold its value.
REQ-021 co = cen & ci & ~ld & terminal, same cycle, no latency; asserted in both SATURATE modes.
REQ-022 ovf SHALL set on any edge where co=1.
REQ-023 ovf SHALL clear on an edge where clr_ovf=1 and co=0; if clr_ovf=1 and co=1 on the same edge, set wins.
REQ-024 A direction change takes effect on the same edge it is sampled; there is no pipeline delay.
REQ-025 When MAXV < 2**WIDTH-1, parOut SHALL never exceed MAXV.
REQ-026 Cascading: co of stage N wired to ci of stage N+1, with shared cen and up, SHALL form a correct multi-digit counter.

Reset
REQ-027 While rst=1, parOut SHALL be 0 and ovf SHALL be 0, immediately and without waiting for clk.
REQ-028 co SHALL follow REQ-021 during reset (parOut=0, so co=cen&ci&~ld&~up).
REQ-029 Reset deasserted mid-count: the first step SHALL occur on the first rising edge after rst falls, counting up from 0.
REQ-030 Reset asserted in the same cycle as ld or a step: reset wins, and the load or step is lost.

Verification
REQ-031 Reset check: WIDTH=4, rst=1 pulsed between edges -> parOut=0 and ovf=0 immediately.
REQ-032 Load and up-count to wrap: WIDTH=4, SATURATE=0, ld parIn=5, then cen=ci=up=1 for 11 edges.
  - Sequence 6..15 then 0.
  - co=1 only in the cycle parOut=15.
  - ovf=1 after the wrap.
REQ-033 Down-count and saturate: SATURATE=1, ld 2, up=0, cen=ci=1 for 4 edges.
  - Sequence 1, 0, 0, 0.
  - co=1 while parOut=0.
REQ-034 Modulus and clamp: WIDTH=4, MAXV=9.
  - Up from 7: 8, 9, 0.
  - ld parIn=12 loads 9.
  - ld=1 with cen=ci=1 at parOut=9: loads parIn, co=0, no ovf set.
REQ-035 Cascade: two stages, MAXV=9, cen=ci=up=1 on stage 0, run 100 edges from 0.
  - Combined count wraps 99 -> 00.
  - Stage-1 ovf sets exactly once.
REQ-036 ovf priority:
  - clr_ovf=1 with co=1 on the same edge -> ovf stays 1.
  - clr_ovf=1 on the next non-terminal edge -> ovf=0.
